// File: rtl/pipe_pkg.sv
// Shared definitions for the operand pipeline stage: control states and default operand width.
package pipe_pkg;

  localparam int XLEN = 32;

  // The state tracks how many pairs are held: none, main only, or main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_operand_reg.sv
// WIDTH-wide two-operand register with load enable and synchronous clear to zero.
import pipe_pkg::*;

module pipe_operand_reg #(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2
);

  logic [WIDTH-1:0] q1_r;
  logic [WIDTH-1:0] q2_r;

  // Operand storage: cleared on reset, loaded on enable, otherwise held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1_r <= {WIDTH{1'b0}};
      q2_r <= {WIDTH{1'b0}};
    end else if (load) begin
      q1_r <= d1;
      q2_r <= d2;
    end else begin
      q1_r <= q1_r;
      q2_r <= q2_r;
    end
  end

  assign q1 = q1_r;
  assign q2 = q2_r;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-operand stage register with valid/ready handshake and a one-entry skid buffer.
// in_ready comes from a flop, so downstream backpressure never reaches upstream combinationally.
import pipe_pkg::*;

module pipe_skid_reg #(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2
);

  state_e           state_r;
  state_e           next_state_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             main_load_s;
  logic             main_from_skid_s;
  logic             skid_load_s;
  logic [WIDTH-1:0] main_d1_s;
  logic [WIDTH-1:0] main_d2_s;
  logic [WIDTH-1:0] skid_q1_s;
  logic [WIDTH-1:0] skid_q2_s;

  assign in_xfer_s  = in_valid && in_ready_r;
  assign out_xfer_s = out_valid_r && out_ready;

  // Next-state and register-load decode; flush squashes every transfer.
  always_comb begin
    next_state_s     = state_r;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      next_state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            main_load_s  = 1'b1;
            next_state_s = ST_BUSY;
          end else begin
            next_state_s = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (in_xfer_s && out_xfer_s) begin
            main_load_s  = 1'b1;
            next_state_s = ST_BUSY;
          end else if (in_xfer_s) begin
            skid_load_s  = 1'b1;
            next_state_s = ST_FULL;
          end else if (out_xfer_s) begin
            next_state_s = ST_EMPTY;
          end else begin
            next_state_s = ST_BUSY;
          end
        end
        ST_FULL: begin
          // The skid entry is older than anything upstream, so it refills main first.
          if (out_xfer_s) begin
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            next_state_s     = ST_BUSY;
          end else begin
            next_state_s = ST_FULL;
          end
        end
        default: begin
          next_state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State plus the handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s != ST_FULL);
      out_valid_r <= (next_state_s != ST_EMPTY);
    end
  end

  assign main_d1_s = main_from_skid_s ? skid_q1_s : in1;
  assign main_d2_s = main_from_skid_s ? skid_q2_s : in2;

  pipe_operand_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load_s),
    .d1    (main_d1_s),
    .d2    (main_d2_s),
    .q1    (out1),
    .q2    (out2)
  );

  pipe_operand_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load_s),
    .d1    (in1),
    .d2    (in2),
    .q1    (skid_q1_s),
    .q2    (skid_q2_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-operand pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
- It is the receiving end of a stage boundary: it accepts operand pairs from the upstream stage and holds them under downstream backpressure without dropping data.
- It replaces bare clocked operand registers wherever a stage can stall (e.g. between decode and execute).
- in_ready is driven from a register, so backpressure never forms a combinational path upstream.

Parameters:
- WIDTH, 32, bit width of each operand (in1/in2, out1/out2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  discard all held entries (branch/exception squash).
- in_valid  input  1  upstream offers the pair in1/in2.
- in_ready  output  1  stage can accept; registered.
- in1  input  WIDTH  first operand from upstream.
- in2  input  WIDTH  second operand from upstream.
- out_valid  output  1  out1/out2 hold a valid pair.
- out_ready  input  1  downstream consumes the pair this cycle.
- out1  output  WIDTH  first operand to downstream.
- out2  output  WIDTH  second operand to downstream.

Behaviour:
- Clock is clk; reset is synchronous and active-low (rst_n sampled only on the rising edge of clk).
- Reset values: out_valid=0, out1=0, out2=0, in_ready=1, skid entry invalid, skid data=0.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Storage: main register drives out1/out2/out_valid directly; skid register holds one overflow pair.
- State machine:
  - EMPTY: main invalid, skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: main and skid valid.
- Transitions, all on the clk edge:
  - EMPTY: input transfer -> main<=in, BUSY. Otherwise stay.
  - BUSY, input only -> skid<=in, FULL.
  - BUSY, output only -> EMPTY.
  - BUSY, both -> main<=in, stay BUSY (full throughput, 1 pair/cycle).
  - BUSY, neither -> stay.
  - FULL: in_ready=0, so no input transfer. Output transfer -> main<=skid, BUSY. Otherwise hold.
- in_ready = (state != FULL), registered, so it updates one cycle after the skid fills or drains.
- Latency: an accepted pair appears on out1/out2 with out_valid=1 the cycle after acceptance when the stage was EMPTY or BUSY with an output transfer.
- Ordering: strictly FIFO; the skid entry is never overtaken.
- Data stability: while out_valid=1 and out_ready=0, out1/out2 hold constant.
- out_valid never drops without an output transfer, except on flush or reset.
- Upstream must hold in1/in2 stable while in_valid=1 and in_ready=0. The block does not check this.
- flush=1 has priority over every transfer:
  - next state EMPTY, in_ready=1, out_valid=0.
  - A pair offered in the flush cycle is discarded.
  - Data registers may keep stale values; only the valid bits are cleared.
- Reset mid-operation: rst_n=0 overrides flush and all transfers; all held pairs are lost.
- out_ready while out_valid=0 has no effect.
- Width: no arithmetic; operands pass through bit-exact at WIDTH.

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
  - default operand width constant XLEN=32.
- One natural sub-module: pipe_operand_reg, a WIDTH-wide two-operand register with load enable and synchronous reset to 0. Instantiate it twice, once for main and once for skid.
- Control FSM stays in pipe_skid_reg.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, in1=32'hDEADBEEF -> out_valid=0, out1=out2=0, in_ready=1 during and after reset.
- Streaming: out_ready=1; drive pairs (1,2),(3,4),(5,6) on consecutive cycles -> outputs appear one cycle later, in order, one per cycle, in_ready stays 1.
- Backpressure/skid: out_ready=0; send (A,B) then (C,D) -> out=(A,B) held; in_ready=0 from the cycle after (C,D) is accepted. Raise out_ready -> (A,B) then (C,D); in_ready returns to 1 one cycle after (A,B) leaves.
- Flush in FULL: reach FULL with (10,20),(30,40); assert flush with in_valid=1, in=(50,60) -> next cycle out_valid=0, in_ready=1, and none of the three pairs ever appears.
- Hold stability: out_valid=1, out_ready=0 for 5 cycles while in1/in2 toggle -> out1/out2 unchanged.
- Reset mid-operation: in FULL, assert rst_n=0 together with flush=0 and out_ready=1 -> next cycle EMPTY, outputs 0, no pair emitted afterward.
